// File: rtl/fft_pkg.sv
// ============================================================================
// fft_pkg - shared constants and complex types for the 16-point FFT datapath.
// Revision 1.0
// ============================================================================
`default_nettype none

package fft_pkg;

  localparam int N_FFT   = 16;
  localparam int K_W     = 3;
  localparam int DATA_W  = 16;
  localparam int TW_W    = 16;
  localparam int TW_FRAC = 14;
  localparam logic [15:0] TW_ONE = 16'h4000;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [TW_W-1:0] re;
    logic signed [TW_W-1:0] im;
  } tw_t;

endpackage

`default_nettype wire

// File: rtl/fft_cmul.sv
// ============================================================================
// fft_cmul - 2-stage enable-gated complex multiplier t = W*B, rounded to
// DATA_W+2 bits (operand register, product register, combinational rounding).
// Revision 1.0
// ============================================================================
`default_nettype none

module fft_cmul import fft_pkg::*; #(
  parameter int DATA_W  = 16,
  parameter int TW_W    = 16,
  parameter int TW_FRAC = 14,
  parameter int OUT_W   = DATA_W + 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [TW_W-1:0]   w_re,
  input  logic signed [TW_W-1:0]   w_im,
  output logic signed [OUT_W-1:0]  t_re,
  output logic signed [OUT_W-1:0]  t_im
);

  localparam int PW = DATA_W + TW_W;
  localparam logic signed [PW:0] RND =
    {{(PW + 1 - TW_FRAC){1'b0}}, 1'b1, {(TW_FRAC - 1){1'b0}}};

  logic signed [DATA_W-1:0] b1_re, b1_im;
  logic signed [TW_W-1:0]   w1_re, w1_im;
  logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
  logic signed [PW:0]       sum_re, sum_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b1_re <= '0;
      b1_im <= '0;
      w1_re <= '0;
      w1_im <= '0;
      p_rr  <= '0;
      p_ii  <= '0;
      p_ri  <= '0;
      p_ir  <= '0;
    end else if (en) begin
      b1_re <= b_re;
      b1_im <= b_im;
      w1_re <= w_re;
      w1_im <= w_im;
      p_rr  <= PW'(b1_re) * PW'(w1_re);
      p_ii  <= PW'(b1_im) * PW'(w1_im);
      p_ri  <= PW'(b1_re) * PW'(w1_im);
      p_ir  <= PW'(b1_im) * PW'(w1_re);
    end
  end

  // One guard bit keeps the sum/difference of two full-range products exact.
  assign sum_re = (PW + 1)'(p_rr) - (PW + 1)'(p_ii) + RND;
  assign sum_im = (PW + 1)'(p_ri) + (PW + 1)'(p_ir) + RND;
  assign t_re   = OUT_W'(sum_re >>> TW_FRAC);
  assign t_im   = OUT_W'(sum_im >>> TW_FRAC);

endmodule

`default_nettype wire

// File: rtl/fft_bfly_r2.sv
// ============================================================================
// fft_bfly_r2 - pipelined radix-2 DIT butterfly X0 = A + W*B, X1 = A - W*B.
// Macro BFLY_SAT_EN: saturate outputs and drive sticky ovf.  Revision 1.0
// ============================================================================
`default_nettype none

module fft_bfly_r2 import fft_pkg::*; #(
  parameter int DATA_W  = 16,
  parameter int TW_W    = 16,
  parameter int TW_FRAC = 14,
  parameter int SCALE   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a_re,
  input  logic signed [DATA_W-1:0] in_a_im,
  input  logic signed [DATA_W-1:0] in_b_re,
  input  logic signed [DATA_W-1:0] in_b_im,
  input  logic [K_W-1:0]           in_k,
  output logic [K_W-1:0]           tw_k,
  input  logic signed [TW_W-1:0]   tw_re,
  input  logic signed [TW_W-1:0]   tw_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_x0_re,
  output logic signed [DATA_W-1:0] out_x0_im,
  output logic signed [DATA_W-1:0] out_x1_re,
  output logic signed [DATA_W-1:0] out_x1_im,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int SW = DATA_W + 3;

  logic                     en;
  logic                     v1, v2;
  logic signed [DATA_W-1:0] a1_re, a1_im, a2_re, a2_im;
  logic signed [DATA_W+1:0] t_re, t_im;
  logic signed [SW-1:0]     sum [4];
  logic signed [SW-1:0]     scl [4];
  logic signed [DATA_W-1:0] red [4];

  // Single global enable: the whole pipe freezes on output back-pressure.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign tw_k     = in_k;

  fft_cmul #(
    .DATA_W (DATA_W),
    .TW_W   (TW_W),
    .TW_FRAC(TW_FRAC),
    .OUT_W  (DATA_W + 2)
  ) u_cmul (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .b_re (in_b_re),
    .b_im (in_b_im),
    .w_re (tw_re),
    .w_im (tw_im),
    .t_re (t_re),
    .t_im (t_im)
  );

  assign sum[0] = SW'(a2_re) + SW'(t_re);
  assign sum[1] = SW'(a2_im) + SW'(t_im);
  assign sum[2] = SW'(a2_re) - SW'(t_re);
  assign sum[3] = SW'(a2_im) - SW'(t_im);

`ifdef BFLY_SAT_EN
  localparam logic signed [SW-1:0] MAX_V = (SW'(1) <<< (DATA_W - 1)) - SW'(1);
  localparam logic signed [SW-1:0] MIN_V = -MAX_V - SW'(1);
  logic [3:0] clip;
`endif

  generate
    for (genvar i = 0; i < 4; i++) begin : g_comp
      if (SCALE != 0) begin : g_scale
        assign scl[i] = (sum[i] + SW'(1)) >>> 1;
      end else begin : g_noscale
        assign scl[i] = sum[i];
      end
`ifdef BFLY_SAT_EN
      assign clip[i] = (scl[i] > MAX_V) || (scl[i] < MIN_V);
      assign red[i]  = (scl[i] > MAX_V) ? DATA_W'(MAX_V) :
                       (scl[i] < MIN_V) ? DATA_W'(MIN_V) : DATA_W'(scl[i]);
`else
      assign red[i] = DATA_W'(scl[i]);
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      a1_re     <= '0;
      a1_im     <= '0;
      a2_re     <= '0;
      a2_im     <= '0;
      out_x0_re <= '0;
      out_x0_im <= '0;
      out_x1_re <= '0;
      out_x1_im <= '0;
    end else if (en) begin
      v1        <= in_valid;
      a1_re     <= in_a_re;
      a1_im     <= in_a_im;
      v2        <= v1;
      a2_re     <= a1_re;
      a2_im     <= a1_im;
      out_valid <= v2;
      out_x0_re <= red[0];
      out_x0_im <= red[1];
      out_x1_re <= red[2];
      out_x1_im <= red[3];
    end
  end

`ifdef BFLY_SAT_EN
  // A clamp landing in the output register beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (en && v2 && (|clip)) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf            = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fft_bfly_r2.sv
// Self-checking bench for fft_bfly_r2: directed plan plus randomized stream,
// checked against an arithmetic butterfly model (SCALE=0 and SCALE=1 instances).
`timescale 1ns/1ps
`default_nettype none

module tb_fft_bfly_r2;

  localparam int ROM_RE [8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
  localparam int ROM_IM [8] = '{0, -6270, -11585, -15137, -16384, -15137, -11585, -6270};

  typedef struct {
    int v [8];
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic ovf_clr = 1'b0;
  logic signed [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic [2:0] k = '0;

  logic in_ready0, in_ready1, o0_valid, o1_valid, ovf0, ovf1;
  logic [2:0] tw0_k, tw1_k;
  logic signed [15:0] tw0_re, tw0_im, tw1_re, tw1_im;
  logic signed [15:0] o0_x0_re, o0_x0_im, o0_x1_re, o0_x1_im;
  logic signed [15:0] o1_x0_re, o1_x0_im, o1_x1_re, o1_x1_im;

  int   n_assert = 0;
  int   n_fail = 0;
  int   n_out = 0;
  exp_t q [$];
  bit   hold_valid = 1'b0;
  logic [127:0] snap;

  always #5 clk = ~clk;

  assign tw0_re = 16'(ROM_RE[tw0_k]);
  assign tw0_im = 16'(ROM_IM[tw0_k]);
  assign tw1_re = 16'(ROM_RE[tw1_k]);
  assign tw1_im = 16'(ROM_IM[tw1_k]);

  fft_bfly_r2 #(.DATA_W(16), .TW_W(16), .TW_FRAC(14), .SCALE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a_re(a_re), .in_a_im(a_im), .in_b_re(b_re), .in_b_im(b_im),
    .in_k(k), .tw_k(tw0_k), .tw_re(tw0_re), .tw_im(tw0_im),
    .out_valid(o0_valid), .out_ready(out_ready),
    .out_x0_re(o0_x0_re), .out_x0_im(o0_x0_im), .out_x1_re(o0_x1_re), .out_x1_im(o0_x1_im),
    .ovf(ovf0), .ovf_clr(ovf_clr)
  );

  fft_bfly_r2 #(.DATA_W(16), .TW_W(16), .TW_FRAC(14), .SCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a_re(a_re), .in_a_im(a_im), .in_b_re(b_re), .in_b_im(b_im),
    .in_k(k), .tw_k(tw1_k), .tw_re(tw1_re), .tw_im(tw1_im),
    .out_valid(o1_valid), .out_ready(out_ready),
    .out_x0_re(o1_x0_re), .out_x0_im(o1_x0_im), .out_x1_re(o1_x1_re), .out_x1_im(o1_x1_im),
    .ovf(ovf1), .ovf_clr(ovf_clr)
  );

  function automatic int reduce(longint s);
    logic signed [15:0] w;
`ifdef BFLY_SAT_EN
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return int'(s);
`else
    w = s[15:0];
    return int'(w);
`endif
  endfunction

  // Exact butterfly arithmetic with round-half-up twiddle product.
  function automatic exp_t model(int ar, int ai, int br, int bi, int kk);
    exp_t   e;
    longint tr, ti;
    longint s [4];
    tr = (longint'(br) * ROM_RE[kk] - longint'(bi) * ROM_IM[kk] + 8192) >>> 14;
    ti = (longint'(br) * ROM_IM[kk] + longint'(bi) * ROM_RE[kk] + 8192) >>> 14;
    s[0] = ar + tr;
    s[1] = ai + ti;
    s[2] = ar - tr;
    s[3] = ai - ti;
    for (int j = 0; j < 4; j++) begin
      e.v[j]     = reduce(s[j]);
      e.v[j + 4] = reduce((s[j] + 1) >>> 1);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ar, input int ai, input int br, input int bi, input int kk);
    a_re = 16'(ar);
    a_im = 16'(ai);
    b_re = 16'(br);
    b_im = 16'(bi);
    k    = 3'(kk);
  endtask

  task automatic drive_rand(input int kk);
    drive(int'($urandom), int'($urandom), int'($urandom), int'($urandom), kk);
  endtask

  // One clock: log accepts, score completed outputs, check stall stability.
  task automatic tick(output bit acc);
    int obs [8];
    exp_t e;
    @(negedge clk);
    acc = in_valid && in_ready0;
    if (acc) q.push_back(model(a_re, a_im, b_re, b_im, int'(k)));
    if (hold_valid) begin
      chk("stall_valid", o1_valid & o0_valid, 1);
      chk("stall_data_stable",
          ({o0_x0_re, o0_x0_im, o0_x1_re, o0_x1_im, o1_x0_re, o1_x0_im, o1_x1_re, o1_x1_im} === snap) ? 1 : 0, 1);
    end
    if (o0_valid && out_ready) begin
      obs = '{o0_x0_re, o0_x0_im, o0_x1_re, o0_x1_im, o1_x0_re, o1_x0_im, o1_x1_re, o1_x1_im};
      if (q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = q.pop_front();
        n_out++;
        for (int j = 0; j < 8; j++) chk($sformatf("result[%0d]", j), obs[j], e.v[j]);
      end
    end
    hold_valid = o0_valid && !out_ready;
    snap = {o0_x0_re, o0_x0_im, o0_x1_re, o0_x1_im, o1_x0_re, o1_x0_im, o1_x1_re, o1_x1_im};
    @(posedge clk);
    #1;
  endtask

  // Accept one butterfly and stop when its result reaches the outputs.
  task automatic run_one(input int ar, input int ai, input int br, input int bi, input int kk);
    bit acc;
    int n;
    drive(ar, ai, br, bi, kk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick(acc);
    chk("accept", acc, 1);
    in_valid = 1'b0;
    n = 1;
    while (!o0_valid && n < 8) begin
      tick(acc);
      n++;
    end
    chk("latency", n, 3);
  endtask

  initial begin
    bit acc;
    int idx, n0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {o0_valid, o1_valid}, 0);
    chk("reset_x0_re", o0_x0_re, 0);
    chk("reset_x1_im", o0_x1_im, 0);
    chk("reset_ovf", ovf0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_idle", in_ready0, 1);

    // W = -j
    run_one(0, 0, 1000, 0, 4);
    chk("t1_x0_re", o0_x0_re, 0);
    chk("t1_x0_im", o0_x0_im, -1000);
    chk("t1_x1_re", o0_x1_re, 0);
    chk("t1_x1_im", o0_x1_im, 1000);
    tick(acc);
    chk("t1_tw_k", tw0_k, k);

    run_one(0, 0, 16384, 0, 2);
    chk("t2_x0_re", o0_x0_re, 11585);
    chk("t2_x0_im", o0_x0_im, -11585);
    chk("t2_x1_re", o0_x1_re, -11585);
    chk("t2_x1_im", o0_x1_im, 11585);
    tick(acc);

    run_one(32767, 0, 32767, 0, 0);
`ifdef BFLY_SAT_EN
    chk("t3_x0_re_sat", o0_x0_re, 32767);
    chk("t3_ovf_set", ovf0, 1);
`else
    chk("t3_x0_re_wrap", o0_x0_re, -2);
    chk("t3_ovf_zero", ovf0, 0);
`endif
    chk("t3_x1_re", o0_x1_re, 0);
    tick(acc);
    ovf_clr = 1'b1;
    tick(acc);
    ovf_clr = 1'b0;
    chk("t3_ovf_cleared", ovf0, 0);

    run_one(3, -3, 0, 0, 0);
    chk("t4_scaled_x0_re", o1_x0_re, 2);
    chk("t4_scaled_x0_im", o1_x0_im, -1);
    chk("t4_scaled_x1_re", o1_x1_re, 2);
    chk("t4_scaled_x1_im", o1_x1_im, -1);
    tick(acc);

    // Eight back-to-back pairs k=0..7 with a 4-cycle downstream stall.
    n0 = n_out;
    idx = 0;
    drive_rand(0);
    in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 5 && c < 9);
      tick(acc);
      if (c == 6) chk("stall_in_ready_low", in_ready0, 0);
      if (acc) begin
        idx++;
        if (idx < 8) drive_rand(idx);
        else in_valid = 1'b0;
      end
    end
    chk("stream_count", n_out - n0, 8);
    chk("stream_queue_empty", q.size(), 0);

    // Randomized valid/ready traffic.
    drive_rand(int'($urandom_range(0, 7)));
    for (int c = 0; c < 200; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
      if (acc) drive_rand(int'($urandom_range(0, 7)));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick(acc);
    chk("random_queue_empty", q.size(), 0);

    // Asynchronous reset with butterflies in flight.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(1234, -567, 2000, 300, 1);
    tick(acc);
    drive_rand(3);
    tick(acc);
    drive_rand(5);
    tick(acc);
    in_valid = 1'b0;
    chk("t6_valid_before_reset", o0_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {o0_valid, o1_valid}, 0);
    chk("t6_async_x0_re", o0_x0_re, 0);
    chk("t6_async_x1_im", o1_x1_im, 0);
    q.delete();
    hold_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_one(-4321, 765, -12345, 23456, 6);
    tick(acc);
    chk("t6_queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
